// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared point widths, frame limit, word-type codes and UART states
package frame_loader_pkg;
  localparam int BRIGHT_W = 6;
  localparam int X_W = 12;
  localparam int Y_W = 12;
  localparam int PT_W = BRIGHT_W + X_W + Y_W;
  localparam int ADDR_W = 11;
  localparam logic [ADDR_W-1:0] MAX_PTS = 11'd2047;
  localparam logic [1:0] WT_POINT = 2'b00;
  localparam logic [1:0] WT_EOF = 2'b11;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/frame_loader_uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling; bytes with a low stop bit are dropped
module uart_rx
  import frame_loader_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200
) (
  input logic clk,
  input logic reset,
  input logic rx,
  output logic [7:0] data,
  output logic valid,
  output logic line
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB + 1);
  uart_state_t state, state_n;
  logic s1, s2, prev, valid_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bits, bits_n;
  logic [7:0] shreg, shreg_n;
  assign line = s2;
  assign data = shreg;
  // synchronizer resets low so a line already low after reset cannot fake a start edge
  always_ff @(posedge clk)
    if (reset) begin
      {s1, s2, prev, valid} <= '0;
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      shreg <= '0;
    end else begin
      {s1, s2, prev} <= {rx, s1, s2};
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      shreg <= shreg_n;
      valid <= valid_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bits_n = bits;
    shreg_n = shreg;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = prev && !s2 ? START : IDLE;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        cnt_n = '0;
        bits_n = '0;
        state_n = s2 ? IDLE : DATA;
      end
      DATA: if (cnt == CW'(CPB - 1)) begin
        cnt_n = '0;
        shreg_n = {s2, shreg[7:1]};
        bits_n = bits + 1'b1;
        state_n = bits == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == CW'(CPB - 1)) begin
        state_n = IDLE;
        valid_n = s2;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/frame_loader.sv
// frame_loader: UART vector-frame receiver into a double-buffered 2x2048 point RAM
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int GAP_CLKS = 50000
) (
  input logic clk,
  input logic reset,
  input logic rx,
  input logic [ADDR_W-1:0] index,
  input logic done_drawing,
  output logic [PT_W-1:0] point,
  output logic [ADDR_W-1:0] num_pts,
  output logic drawing,
  output logic test
);
  localparam int GW = $clog2(GAP_CLKS + 1);
  logic [7:0] data;
  logic valid, line, bank, pending, wv, pt_ok, eof_ok, swap, gap;
  logic [1:0] bcnt;
  logic [23:0] wbuf;
  logic [31:0] word;
  logic [ADDR_W-1:0] wcount, fcount;
  logic [GW-1:0] gcnt;
  logic [PT_W-1:0] mem [2**(ADDR_W+1)];
  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (.clk, .reset, .rx, .data, .valid, .line);
  assign word = {wbuf, data};
  assign wv = valid && bcnt == 2'd3;
  assign pt_ok = wv && word[31:30] == WT_POINT && !pending && wcount != MAX_PTS;
  assign eof_ok = wv && word[31:30] == WT_EOF && !pending && wcount != '0;
  assign swap = pending && (done_drawing || !drawing);
  assign gap = gcnt == GW'(GAP_CLKS);
  // bank selects the display half; points always land in the other half
  always_ff @(posedge clk)
    if (pt_ok) mem[{~bank, wcount}] <= word[PT_W-1:0];
  always_ff @(posedge clk)
    if (reset) begin
      {bank, pending, drawing, test} <= '0;
      {bcnt, wbuf, gcnt} <= '0;
      {wcount, fcount, num_pts} <= '0;
      point <= '0;
    end else begin
      test <= test ^ valid;
      gcnt <= !line ? '0 : gcnt + GW'(!gap);
      bcnt <= valid ? bcnt + 2'd1 : gap ? 2'd0 : bcnt;
      wbuf <= valid ? {wbuf[15:0], data} : wbuf;
      wcount <= pt_ok ? wcount + 1'b1 : eof_ok ? '0 : wcount;
      fcount <= eof_ok ? wcount : fcount;
      pending <= eof_ok || (pending && !swap);
      bank <= bank ^ swap;
      num_pts <= swap ? fcount : num_pts;
      drawing <= drawing || swap;
      point <= mem[{bank ^ swap, index}];
    end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed UART frames against hand-computed point/count expectations
module tb_frame_loader;
  localparam int CLK_HZ = 230400;
  localparam int BAUD = 115200;
  localparam int CPB = CLK_HZ / BAUD;
  localparam int GAP = 64;
  localparam logic [31:0] EOF_W = 32'hC000_0000;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, done_drawing = 1'b0;
  logic [10:0] index = '0;
  logic [29:0] point, v;
  logic [10:0] num_pts;
  logic drawing, test, t0;
  int n_checks = 0, n_fail = 0;
  frame_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_CLKS(GAP)) dut (
    .clk(clk), .reset(reset), .rx(rx), .index(index), .done_drawing(done_drawing),
    .point(point), .num_pts(num_pts), .drawing(drawing), .test(test));
  always #5 clk = ~clk;
  function automatic logic [29:0] pt_val(input int i);
    logic [11:0] q;
    q = 12'(i);
    return {q[5:0], q ^ 12'hA5A, q};
  endfunction
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic pulse_done();
    done_drawing = 1'b1;
    idle(1);
    done_drawing = 1'b0;
  endtask
  task automatic rd(input int i, output logic [29:0] r);
    index = 11'(i);
    idle(1);
    r = point;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_checks++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL reset_drawing got %b exp 0", drawing); end
    n_checks++; if (num_pts !== 11'd0) begin n_fail++; $display("FAIL reset_num_pts got %0d exp 0", num_pts); end
    n_checks++; if (point !== 30'd0) begin n_fail++; $display("FAIL reset_point got %h exp 0", point); end
    n_checks++; if (test !== 1'b0) begin n_fail++; $display("FAIL reset_test got %b exp 0", test); end
    reset = 1'b0;
    idle(4);
  endtask
  task automatic test_single_frame();
    logic [29:0] p [3];
    p = '{30'h1234_5678, 30'h3FFF_FFFF, 30'h0000_0001};
    for (int i = 0; i < 3; i++) send_word({2'b00, p[i]});
    send_word(EOF_W);
    idle(6);
    n_checks++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL single_drawing got %b exp 1", drawing); end
    n_checks++; if (num_pts !== 11'd3) begin n_fail++; $display("FAIL single_num_pts got %0d exp 3", num_pts); end
    n_checks++; if (test !== 1'b0) begin n_fail++; $display("FAIL single_test_parity got %b exp 0", test); end
    rd(0, v);
    n_checks++; if (v !== p[0]) begin n_fail++; $display("FAIL single_pt0 got %h exp %h", v, p[0]); end
    for (int i = 1; i < 3; i++) begin
      index = 11'(i);
      n_checks++; if (point !== p[i-1]) begin n_fail++; $display("FAIL single_pt_latency%0d got %h exp %h", i, point, p[i-1]); end
      idle(1);
      n_checks++; if (point !== p[i]) begin n_fail++; $display("FAIL single_pt%0d got %h exp %h", i, point, p[i]); end
    end
  endtask
  task automatic test_double_buffer();
    for (int i = 0; i < 2; i++) send_word({2'b00, pt_val(100 + i)});
    send_word(EOF_W);
    idle(6);
    n_checks++; if (num_pts !== 11'd3) begin n_fail++; $display("FAIL dbuf_a_wait got %0d exp 3", num_pts); end
    pulse_done();
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL dbuf_a_swap got %0d exp 2", num_pts); end
    for (int i = 0; i < 5; i++) send_word({2'b00, pt_val(200 + i)});
    send_word(EOF_W);
    idle(6);
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL dbuf_b_hold got %0d exp 2", num_pts); end
    rd(1, v);
    n_checks++; if (v !== pt_val(101)) begin n_fail++; $display("FAIL dbuf_a_pt1 got %h exp %h", v, pt_val(101)); end
    done_drawing = 1'b1;
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL dbuf_pre_edge got %0d exp 2", num_pts); end
    idle(1);
    done_drawing = 1'b0;
    n_checks++; if (num_pts !== 11'd5) begin n_fail++; $display("FAIL dbuf_b_swap got %0d exp 5", num_pts); end
    n_checks++; if (point !== pt_val(201)) begin n_fail++; $display("FAIL dbuf_swap_point got %h exp %h", point, pt_val(201)); end
    rd(4, v);
    n_checks++; if (v !== pt_val(204)) begin n_fail++; $display("FAIL dbuf_b_pt4 got %h exp %h", v, pt_val(204)); end
    pulse_done();
    idle(2);
    n_checks++; if (num_pts !== 11'd5) begin n_fail++; $display("FAIL redraw_num_pts got %0d exp 5", num_pts); end
    rd(4, v);
    n_checks++; if (v !== pt_val(204)) begin n_fail++; $display("FAIL redraw_pt4 got %h exp %h", v, pt_val(204)); end
  endtask
  task automatic test_eof_zero();
    send_word(EOF_W);
    idle(6);
    pulse_done();
    idle(2);
    n_checks++; if (num_pts !== 11'd5) begin n_fail++; $display("FAIL eof_zero_num_pts got %0d exp 5", num_pts); end
    n_checks++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL eof_zero_drawing got %b exp 1", drawing); end
  endtask
  task automatic test_eof_with_done();
    send_word({2'b00, pt_val(300)});
    for (int i = 3; i > 0; i--) send_byte(EOF_W[8*i +: 8], 1'b1);
    // the last byte's word is consumed on the 23rd edge after its start bit is driven
    fork
      send_byte(EOF_W[7:0], 1'b1);
      begin
        repeat (22) @(posedge clk);
        #1 done_drawing = 1'b1;
        @(posedge clk);
        #1 done_drawing = 1'b0;
      end
    join
    idle(4);
    n_checks++; if (num_pts !== 11'd5) begin n_fail++; $display("FAIL coincide_no_swap got %0d exp 5", num_pts); end
    pulse_done();
    n_checks++; if (num_pts !== 11'd1) begin n_fail++; $display("FAIL coincide_late_swap got %0d exp 1", num_pts); end
    rd(0, v);
    n_checks++; if (v !== pt_val(300)) begin n_fail++; $display("FAIL coincide_pt0 got %h exp %h", v, pt_val(300)); end
  endtask
  task automatic test_pending_discard();
    for (int i = 0; i < 2; i++) send_word({2'b00, pt_val(400 + i)});
    send_word(EOF_W);
    idle(6);
    n_checks++; if (num_pts !== 11'd1) begin n_fail++; $display("FAIL pend_hold got %0d exp 1", num_pts); end
    for (int i = 0; i < 3; i++) send_word({2'b00, pt_val(500 + i)});
    send_word(EOF_W);
    idle(6);
    pulse_done();
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL pend_swap got %0d exp 2", num_pts); end
    rd(1, v);
    n_checks++; if (v !== pt_val(401)) begin n_fail++; $display("FAIL pend_pt1 got %h exp %h", v, pt_val(401)); end
    pulse_done();
    idle(2);
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL pend_discarded got %0d exp 2", num_pts); end
  endtask
  task automatic test_framing();
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(GAP + 1);
    send_word({2'b00, pt_val(600)});
    send_word(EOF_W);
    idle(6);
    pulse_done();
    n_checks++; if (num_pts !== 11'd1) begin n_fail++; $display("FAIL gap_num_pts got %0d exp 1", num_pts); end
    rd(0, v);
    n_checks++; if (v !== pt_val(600)) begin n_fail++; $display("FAIL gap_pt0 got %h exp %h", v, pt_val(600)); end
  endtask
  task automatic test_bad_stop();
    logic [31:0] w;
    w = {2'b00, pt_val(700)};
    t0 = test;
    send_byte(8'h5A, 1'b0);
    rx = 1'b1;
    idle(4);
    n_checks++; if (test !== t0) begin n_fail++; $display("FAIL badstop_test got %b exp %b", test, t0); end
    send_byte(w[31:24], 1'b1);
    idle(3);
    n_checks++; if (test !== ~t0) begin n_fail++; $display("FAIL goodbyte_test got %b exp %b", test, ~t0); end
    for (int i = 2; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    send_word(EOF_W);
    idle(6);
    pulse_done();
    n_checks++; if (num_pts !== 11'd1) begin n_fail++; $display("FAIL badstop_num_pts got %0d exp 1", num_pts); end
    rd(0, v);
    n_checks++; if (v !== pt_val(700)) begin n_fail++; $display("FAIL badstop_pt0 got %h exp %h", v, pt_val(700)); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 2050; i++) send_word({2'b00, pt_val(i)});
    send_word(EOF_W);
    idle(6);
    pulse_done();
    n_checks++; if (num_pts !== 11'd2047) begin n_fail++; $display("FAIL ovf_num_pts got %0d exp 2047", num_pts); end
    rd(0, v);
    n_checks++; if (v !== pt_val(0)) begin n_fail++; $display("FAIL ovf_pt0 got %h exp %h", v, pt_val(0)); end
    rd(2046, v);
    n_checks++; if (v !== pt_val(2046)) begin n_fail++; $display("FAIL ovf_pt2046 got %h exp %h", v, pt_val(2046)); end
  endtask
  task automatic test_reset_mid_byte();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        n_checks++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL midrst_drawing got %b exp 0", drawing); end
        n_checks++; if (num_pts !== 11'd0) begin n_fail++; $display("FAIL midrst_num_pts got %0d exp 0", num_pts); end
        n_checks++; if (point !== 30'd0) begin n_fail++; $display("FAIL midrst_point got %h exp 0", point); end
        n_checks++; if (test !== 1'b0) begin n_fail++; $display("FAIL midrst_test got %b exp 0", test); end
        reset = 1'b0;
      end
    join
    idle(10);
    for (int i = 0; i < 2; i++) send_word({2'b00, pt_val(800 + i)});
    send_word(EOF_W);
    idle(6);
    n_checks++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL postrst_drawing got %b exp 1", drawing); end
    n_checks++; if (num_pts !== 11'd2) begin n_fail++; $display("FAIL postrst_num_pts got %0d exp 2", num_pts); end
    for (int i = 0; i < 2; i++) begin
      rd(i, v);
      n_checks++; if (v !== pt_val(800 + i)) begin n_fail++; $display("FAIL postrst_pt%0d got %h exp %h", i, v, pt_val(800 + i)); end
    end
  endtask
  initial begin
    #4_000_000;
    $display("FAIL watchdog timeout after %0d assertions", n_checks);
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_double_buffer();
    test_eof_zero();
    test_eof_with_done();
    test_pending_discard();
    test_framing();
    test_bad_stop();
    test_overflow();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate.
REQ-003 SHALL have parameter GAP_CLKS, default 50000, idle-line clocks that force byte realignment.
REQ-004 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  UART line, 8N1 format, idle high, asynchronous to clk.
REQ-007 SHALL have port index  input  11  read address into the display bank.
REQ-008 SHALL have port done_drawing  input  1  one-cycle pulse: the consumer finished the display bank.
REQ-009 SHALL have port point  output  30  {brightness[5:0], x[11:0], y[11:0]} at the display-bank address.
REQ-010 SHALL have port num_pts  output  11  point count of the display bank.
REQ-011 SHALL have port drawing  output  1  high while the display bank holds a valid frame.
REQ-012 SHALL have port test  output  1  toggles once per received UART byte.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer, detect the start bit on a falling edge, sample each bit at mid-bit (CLK_HZ/BAUD clocks per bit), and drop any byte whose stop bit is 0.
REQ-014 SHALL assemble 4 bytes, MSB first, into one 32-bit word; word[31:30]=00 is a point, so point data is word[29:0].
REQ-015 SHALL treat word[31:30]=11 as end-of-frame (EOF) and discard words with word[31:30]=01 or 10.
REQ-016 SHALL reset the byte-in-word counter to 0 when rx stays idle for GAP_CLKS clocks; a partial word is discarded.
REQ-017 SHALL hold two banks of 2048x30 RAM (write bank and display bank); each point word is written to the write bank at address wcount, and wcount then increments.
REQ-018 SHALL drop point words once wcount=2047; the maximum frame size is 2047 points.
REQ-019 SHALL ignore an EOF that arrives with wcount=0, with no state change.
REQ-020 SHALL, on an EOF with wcount>0, set pending, latch the frame count to wcount, and clear wcount.
REQ-021 SHALL discard every incoming point word and EOF while pending=1.
REQ-022 SHALL swap banks when pending=1 and (done_drawing=1 or drawing=0), evaluated on registered pending; the swap sets num_pts to the latched count, sets drawing=1, and clears pending, all in the same edge.
REQ-023 SHALL NOT swap on an EOF that coincides with done_drawing; the current frame redraws and the swap waits for the next done_drawing.
REQ-024 SHALL NOT swap on done_drawing with pending=0; the display bank is redrawn unchanged.
REQ-025 SHALL present point registered, exactly one cycle after index is sampled; an index>=num_pts returns don't-care data.
REQ-026 SHALL keep point and num_pts stable except at a swap.
REQ-027 SHALL keep drawing=1 after the first swap until reset.

Reset
REQ-028 SHALL, in the reset cycle, clear the following: drawing=0, num_pts=0, point=0, test=0, pending=0, wcount=0, byte counter=0, UART FSM to IDLE, bank select=0.
REQ-029 SHALL abandon any byte or frame in progress at reset; RAM contents need not clear.
REQ-030 SHALL treat a reset mid-byte like power-up; the next byte is received only after a new falling edge.

Structure
REQ-031 SHALL put the following in the shared vector package: the point field widths (6/12/12), MAX_PTS=2047, and the word-type codes (POINT=2'b00, EOF=2'b11).
REQ-032 SHALL implement the UART receiver as sub-module uart_rx (clk, reset, rx -> data[7:0], valid pulse), with states IDLE, START, DATA, STOP.
REQ-033 SHALL infer the RAM as a single 4096x30 array addressed by {bank, addr}.

Verification
REQ-034 SHALL test a single frame: 3 points then EOF at 115200 baud -> drawing=1, num_pts=3, and point at index 0..2 equals the sent words 1 cycle later.
REQ-035 SHALL test double buffering: frame A (2 pts) is displayed and frame B (5 pts) is sent -> num_pts stays 2 until a done_drawing pulse, then becomes 5 at the next edge.
REQ-036 SHALL test boundary cases: 2050 points plus EOF -> num_pts=2047; an EOF with 0 points -> no change; EOF and done_drawing in the same cycle -> swap only at the following done_drawing.
REQ-037 SHALL test framing recovery: 2 bytes, then a gap of GAP_CLKS+1 clocks, then a full point -> exactly 1 point is stored; a byte with stop bit 0 -> test does not toggle and the byte is dropped.
REQ-038 SHALL test a frame received while pending=1 -> it is discarded; a reset in the middle of the 3rd byte -> all outputs are 0, and the next clean frame loads correctly.
